// File: rtl/memory_banked.sv
// memory_banked: N_BANKS parallel RAM banks sharing read/write addresses, zeroed by a CLEAR sweep after reset.
// Optional macro MEMORY_BANKED_FWD_EN selects write-first forwarding on read/write address collisions.
module memory_banked #(
  parameter int unsigned RAM_WIDTH    = 13,
  parameter int unsigned NB_ADDRESS   = 10,
  parameter int unsigned N_BANKS      = 3,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                           i_CLK,
  input  logic                           i_reset,
  input  logic [N_BANKS-1:0]             i_wrEnable,
  input  logic [NB_ADDRESS-1:0]          i_writeAdd,
  input  logic [N_BANKS*RAM_WIDTH-1:0]   i_data,
  input  logic                           i_rdEnable,
  input  logic [NB_ADDRESS-1:0]          i_readAdd,
  output logic [N_BANKS*RAM_WIDTH-1:0]   o_data,
  output logic                           o_valid,
  output logic                           o_ready
);

  localparam int unsigned DEPTH = 2**NB_ADDRESS;
  localparam int unsigned DW    = N_BANKS*RAM_WIDTH;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                  state_q;
  logic [NB_ADDRESS-1:0]   clr_cnt_q;
  logic                    ready_q;
  logic [RAM_WIDTH-1:0]    mem_q [N_BANKS][DEPTH];
  logic [DW-1:0]           o_data_q;
  logic                    o_valid_q;

  logic                    clearing_c;
  logic                    wr_acc_c;
  logic                    rd_acc_c;
  logic [DW-1:0]           rd_word_c;

  // Clear sweep: one address per cycle, then RUN until the next reset.
  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= (state_q == RUN);
      if (state_q == CLEAR) begin
        clr_cnt_q <= clr_cnt_q + NB_ADDRESS'(1);
        if (clr_cnt_q == NB_ADDRESS'(DEPTH-1)) begin
          state_q <= RUN;
        end
      end
    end
  end

  // Requests are honoured only once o_ready is visible, never on a reset edge.
  assign clearing_c = (state_q == CLEAR) && !i_reset;
  assign wr_acc_c   = ready_q && !i_reset;
  assign rd_acc_c   = ready_q && i_rdEnable && !i_reset;

  // Bank storage; deliberately not reset so only the sweep zeroes it.
  always_ff @(posedge i_CLK) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (clearing_c) begin
        mem_q[b][clr_cnt_q] <= '0;
      end else if (wr_acc_c && i_wrEnable[b]) begin
        mem_q[b][i_writeAdd] <= i_data[b*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word_c = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      rd_word_c[b*RAM_WIDTH +: RAM_WIDTH] = mem_q[b][i_readAdd];
`ifdef MEMORY_BANKED_FWD_EN
      if (i_wrEnable[b] && (i_writeAdd == i_readAdd)) begin
        rd_word_c[b*RAM_WIDTH +: RAM_WIDTH] = i_data[b*RAM_WIDTH +: RAM_WIDTH];
      end
`endif
    end
  end

  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("memory_banked: READ_LATENCY must be 1 or 2");
  end else if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge i_CLK) begin
      if (i_reset) begin
        o_data_q  <= '0;
        o_valid_q <= 1'b0;
      end else begin
        o_valid_q <= rd_acc_c;
        if (rd_acc_c) begin
          o_data_q <= rd_word_c;
        end
      end
    end
  end else begin : g_lat2
    logic [DW-1:0] s1_data_q;
    logic          s1_valid_q;

    // Extra pipeline stage; data is captured at acceptance so later writes cannot disturb it.
    always_ff @(posedge i_CLK) begin
      if (i_reset) begin
        s1_data_q  <= '0;
        s1_valid_q <= 1'b0;
        o_data_q   <= '0;
        o_valid_q  <= 1'b0;
      end else begin
        s1_valid_q <= rd_acc_c;
        if (rd_acc_c) begin
          s1_data_q <= rd_word_c;
        end
        o_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          o_data_q <= s1_data_q;
        end
      end
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_ready = ready_q;

endmodule

// File: doc/memory_banked.md
MEMORY_BANKED -- requirements
Module: memory_banked

Interface
REQ-001 SHALL provide parameter RAM_WIDTH, default 13, width of one bank word in bits.
REQ-002 SHALL provide parameter NB_ADDRESS, default 10, address width; depth per bank DEPTH = 2**NB_ADDRESS.
REQ-003 SHALL provide parameter N_BANKS, default 3, number of parallel banks sharing one address.
REQ-004 SHALL provide parameter READ_LATENCY, default 1, legal values 1 or 2; any other value SHALL fail elaboration.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-006 i_CLK  input  1  sole clock; all state updates on rising edge.
REQ-007 i_reset  input  1  synchronous active-high reset.
REQ-008 i_wrEnable  input  N_BANKS  per-bank write enable; bit b writes bank b.
REQ-009 i_writeAdd  input  NB_ADDRESS  write address, common to all banks.
REQ-010 i_data  input  N_BANKS*RAM_WIDTH  write data; bank b at bits [b*RAM_WIDTH +: RAM_WIDTH].
REQ-011 i_rdEnable  input  1  read request.
REQ-012 i_readAdd  input  NB_ADDRESS  read address, common to all banks.
REQ-013 o_data  output  N_BANKS*RAM_WIDTH  read data, same bank packing as i_data.
REQ-014 o_valid  output  1  one-cycle pulse marking o_data as a fresh read result.
REQ-015 o_ready  output  1  high once clearing is done; reads and writes accepted only while high.

Function
REQ-016 FSM SHALL have two states: CLEAR and RUN.
REQ-017 CLEAR: internal counter 0..DEPTH-1, one address per cycle, writes zero to every bank; after address DEPTH-1 is written, next state RUN.
REQ-018 The first edge with i_reset low clears address 0; o_ready SHALL rise DEPTH cycles after that edge, with all DEPTH addresses cleared (no off-by-one).
REQ-019 In CLEAR, i_wrEnable and i_rdEnable SHALL be ignored; no user write lands, no o_valid pulse.
REQ-020 In RUN, o_ready=1; the FSM stays in RUN until reset.
REQ-021 Write: in RUN, at an edge with i_wrEnable[b]=1, bank b at i_writeAdd SHALL take its i_data slice; banks with a 0 enable bit SHALL be unchanged.
REQ-022 Read: an i_rdEnable accepted at edge k SHALL give o_data and o_valid=1 after edge k+READ_LATENCY-1, i.e. visible in the cycle after edge k (latency 1) or after edge k+1 (latency 2).
REQ-023 Reads SHALL be fully pipelined: one per cycle, back-to-back, results returned in order.
REQ-024 o_valid SHALL be high for exactly one cycle per accepted read; o_data SHALL hold its last value when no read completes.
REQ-025 Read/write collision (same address, same edge, in RUN): behaviour set by REQ-030/031; banks not written SHALL always return stored data.
REQ-026 Read and write on different addresses in the same cycle SHALL both complete with no interaction.

Reset
REQ-027 While i_reset=1: o_data=0, o_valid=0, o_ready=0, state=CLEAR, counter=0, read pipeline valid bits cleared.
REQ-028 Reset asserted mid-CLEAR or mid-RUN SHALL drop in-flight reads (no o_valid) and restart clearing at address 0.
REQ-029 Memory contents SHALL NOT be cleared by i_reset itself; only the CLEAR sweep zeroes them.

Configuration
REQ-030 Macro MEMORY_BANKED_FWD_EN defined: collision read SHALL return the new i_data slice for each written bank (write-first forwarding).
REQ-031 Macro MEMORY_BANKED_FWD_EN undefined: collision read SHALL return the pre-write contents of every bank (read-first); no forwarding logic is built.

Verification (NB_ADDRESS=4, N_BANKS=3, RAM_WIDTH=13)
REQ-032 Release reset at edge 0, hold rd/wr requests -> o_ready=0 for 16 cycles, rises after edge 16; no o_valid; reading all 16 addresses then returns 0.
REQ-033 RUN; write wrEnable=3'b101, addr 5, data {13'h0AA,13'h0BB,13'h0CC}; read addr 5 next cycle -> o_data {0AA,000,0CC}, o_valid pulses once, at READ_LATENCY 1 and 2.
REQ-034 Back-to-back reads of addrs 0..15 for 16 cycles after distinct writes -> 16 consecutive o_valid pulses, data in order, no gaps.
REQ-035 Addr 7 holds 13'h111 in all banks; write 13'h1FF to all banks and read addr 7 on the same edge -> 1FF per bank with MEMORY_BANKED_FWD_EN, 111 without.
REQ-036 Assert i_reset at counter=9 in CLEAR, and separately with a read in flight in RUN -> o_valid stays 0, o_ready=0, clear restarts at 0, o_ready rises 16 cycles after reset release.
REQ-037 Write during CLEAR at addr 3 with 13'h055 -> after o_ready, reading addr 3 returns 0.
